// File: rtl/isa_pkg.sv
// Shared ISA constants and sequencer state encoding, used by the fetch
// controller and by any debug/trace logic that decodes state_o.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_DECODE = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    // True for opcodes the sequencer resolves itself without the execute unit.
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register: jump load takes priority over increment,
// increment wraps modulo 2^ADDR_W.
module pc_unit #(
    parameter int                ADDR_W   = 30,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_val;
        end else if (inc_en) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller: drives instruction fetches, pulses the IR
// load, redirects the PC on jumps and hands other ops to the execute unit.
module fetch_sequencer #(
    parameter int                ADDR_W   = 30,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              ir_load,
    input  logic [3:0]        ir_opcode,
    input  logic [ADDR_W-1:0] ir_target,
    output logic              exec_start,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err,
    output logic [2:0]        state_o
);

    import isa_pkg::*;

    // Counter value seen on the last permitted WAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       pc_load;
    logic       pc_inc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                // An ack on the limit cycle still wins over the timeout.
                if (mem_ack)                    state_nxt = ST_DECODE;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_ERR;
            end
            ST_DECODE: begin
                if (ir_opcode == OP_HALT)         state_nxt = ST_HALT;
                else if (is_ctrl_op(ir_opcode))   state_nxt = ST_FETCH;
                else                              state_nxt = ST_EXEC;
            end
            ST_EXEC:   if (exec_done) state_nxt = ST_FETCH;
            ST_HALT:   if (start) state_nxt = ST_FETCH;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign pc_load = (state == ST_DECODE) && (ir_opcode == OP_JMP);
    assign pc_inc  = ((state == ST_DECODE) && (ir_opcode == OP_NOP))
                   || ((state == ST_EXEC) && exec_done)
                   || ((state == ST_HALT) && start);

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_en  (pc_load),
        .load_val (ir_target),
        .inc_en   (pc_inc),
        .pc       (pc)
    );

    // Strobes decode straight from state so reset drops them asynchronously.
    assign mem_req    = (state == ST_FETCH) || (state == ST_WAIT);
    assign mem_addr   = pc;
    assign ir_load    = (state == ST_WAIT) && mem_ack;
    assign exec_start = (state == ST_DECODE) && !is_ctrl_op(ir_opcode);
    assign halted     = (state == ST_HALT);
    assign fetch_err  = (state == ST_ERR);
    assign state_o    = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural memory/execute responders, a fetch
// address scoreboard, a table of instruction vectors and corner-case sequences.
module tb_fetch_sequencer;

    import isa_pkg::*;

    localparam int AW = 30;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          ir_load;
    logic [3:0]    ir_opcode;
    logic [AW-1:0] ir_target;
    logic          exec_start;
    logic          exec_done;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fetch_err;
    logic [2:0]    state_o;

    fetch_sequencer #(
        .ADDR_W   (AW),
        .RESET_PC (30'd0),
        .WAIT_MAX (15)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .ir_load    (ir_load),
        .ir_opcode  (ir_opcode),
        .ir_target  (ir_target),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .pc         (pc),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .state_o    (state_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] tgt;
        int            ack_lat;
        int            exec_lat;
        logic [AW-1:0] exp_next;
        int            exp_starts;
        int            exp_cyc;
    } vec_t;

    vec_t          vecs [9];
    logic [AW-1:0] exp_q [$];

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            wait_cnt_tb = 0;
    int            ex_cnt   = 0;
    int            ack_lat  = 0;
    int            exec_lat = 0;
    int            n_load   = 0;
    int            n_start  = 0;
    int            fetch_cyc = 0;
    bit            fetch_seen = 1'b0;
    logic [3:0]    cur_op  = 4'h0;
    logic [AW-1:0] cur_tgt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: observed 0x%0h, event not expected or not reached", name, act);
    endtask

    // One cycle: respond as memory/execute unit, then sample and score fetches.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (state_o == ST_WAIT) begin
            mem_ack = (wait_cnt_tb == ack_lat);
            if (mem_ack) begin
                ir_opcode = cur_op;
                ir_target = cur_tgt;
            end
            wait_cnt_tb++;
        end else begin
            mem_ack     = 1'b0;
            wait_cnt_tb = 0;
        end
        if (state_o == ST_EXEC) begin
            exec_done = (ex_cnt == exec_lat);
            ex_cnt++;
        end else begin
            exec_done = 1'b0;
            ex_cnt    = 0;
        end
        #1;
        if (ir_load)    n_load++;
        if (exec_start) n_start++;
        if (state_o == ST_FETCH) begin
            fetch_seen = 1'b1;
            fetch_cyc  = cyc;
            check("fetch_mem_req", 32'(mem_req), 32'd1);
            if (exp_q.size() == 0) fail("sb_unexpected_fetch", 32'(mem_addr));
            else check("sb_fetch_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_to_fetch(input int limit, input string name);
        fetch_seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (fetch_seen) break;
        end
        if (!fetch_seen) fail(name, 32'(state_o));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_strobes"}, 32'({mem_req, ir_load, exec_start, halted, fetch_err}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle 0x%0h", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n_wait;

        vecs[0] = '{OP_NOP,  30'h0,        0, 0, 30'd1,        0, 3};
        vecs[1] = '{OP_NOP,  30'h0,        0, 0, 30'd2,        0, 3};
        vecs[2] = '{OP_NOP,  30'h0,        0, 0, 30'd3,        0, 3};
        vecs[3] = '{OP_JMP,  30'h100,      0, 0, 30'h100,      0, 3};
        vecs[4] = '{4'h3,    30'h0,        0, 4, 30'h101,      1, 8};
        vecs[5] = '{4'h5,    30'h0,        2, 0, 30'h102,      1, 6};
        vecs[6] = '{OP_JMP,  30'h3FFFFFFF, 0, 0, 30'h3FFFFFFF, 0, 3};
        vecs[7] = '{OP_NOP,  30'h0,        0, 0, 30'd0,        0, 3};
        vecs[8] = '{OP_JMP,  30'd7,        0, 0, 30'd7,        0, 3};

        reset_n   = 1'b0;
        start     = 1'b0;
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        ir_opcode = 4'h0;
        ir_target = '0;
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs("reset");

        reset_n = 1'b1;
        exp_q.push_back(30'd0);
        start = 1'b1;
        tick();
        start = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cur_op   = vecs[i].op;
            cur_tgt  = vecs[i].tgt;
            ack_lat  = vecs[i].ack_lat;
            exec_lat = vecs[i].exec_lat;
            exp_q.push_back(vecs[i].exp_next);
            n_load  = 0;
            n_start = 0;
            c0 = fetch_cyc;
            run_to_fetch(60, $sformatf("v%0d_no_fetch", i));
            check($sformatf("v%0d_cycles", i), 32'(fetch_cyc - c0), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_ir_load", i), 32'(n_load), 32'd1);
            check($sformatf("v%0d_exec_start", i), 32'(n_start), 32'(vecs[i].exp_starts));
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_next));
        end

        // HALT at pc=7, then resume at 8.
        cur_op  = OP_HALT;
        ack_lat = 0;
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) break;
        end
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_state", 32'(state_o), 32'(ST_HALT));
        repeat (3) tick();
        check("halt_pc_frozen", 32'(pc), 32'd7);
        check("halt_no_exec", 32'(n_start), 32'd0);
        exp_q.push_back(30'd8);
        start = 1'b1;
        fetch_seen = 1'b0;
        tick();
        start = 1'b0;
        check("halt_resume_fetch", 32'(fetch_seen), 32'd1);
        check("halt_released", 32'(halted), 32'd0);

        // Memory never acknowledges: error after 15 WAIT cycles.
        ack_lat = 1000;
        n_wait  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state_o == ST_WAIT) n_wait++;
            else break;
        end
        check("tmo_wait_cycles", 32'(n_wait), 32'd15);
        check("tmo_state", 32'(state_o), 32'(ST_ERR));
        check("tmo_fetch_err", 32'(fetch_err), 32'd1);
        check("tmo_mem_req", 32'(mem_req), 32'd0);
        check("tmo_pc", 32'(pc), 32'd8);
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        check("tmo_sticky_state", 32'(state_o), 32'(ST_ERR));
        check("tmo_sticky_err", 32'(fetch_err), 32'd1);

        // Reset clears the error; ack on the 15th WAIT cycle is accepted.
        reset_n = 1'b0;
        #1;
        check_reset_outputs("err_reset");
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(30'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cur_op  = OP_NOP;
        ack_lat = 14;
        exp_q.push_back(30'd1);
        c0 = fetch_cyc;
        run_to_fetch(40, "late_ack_no_fetch");
        check("late_ack_cycles", 32'(fetch_cyc - c0), 32'd17);
        check("late_ack_no_err", 32'(fetch_err), 32'd0);

        // Reset dropped mid-EXEC, followed by stray exec_done/mem_ack.
        cur_op   = 4'h3;
        ack_lat  = 0;
        exec_lat = 4;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state_o == ST_EXEC) break;
        end
        check("rst_exec_reached", 32'(state_o), 32'(ST_EXEC));
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("exec_reset");
        @(negedge clock);
        reset_n   = 1'b1;
        exec_done = 1'b1;
        mem_ack   = 1'b1;
        @(negedge clock);
        exec_done = 1'b0;
        mem_ack   = 1'b0;
        #1;
        check_reset_outputs("stray_done");

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
